wts_channel_mixer: RTL and testbench
====================================

WTS_CHANNEL_MIXER -- requirements
Module: wts_channel_mixer

Interface
REQ-001 The module SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Port list SHALL be, clock and reset first:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- active  in  3  slot index; 0..4 = channel a..e, 5..7 = no operation
- envelope  in  7  unsigned envelope for the slot on `active`, same cycle; 0..64 nominal
- wave_data  in  8  signed wave sample for the slot on `active`, same cycle
- reg_volume_a..reg_volume_e  in  4 each  unsigned channel volume, 0..15
- reg_ch_enable  in  5  per-channel enable, bit0 = a .. bit4 = e
- sound_out  out  15  signed mixed sample
- sound_valid  out  1  one-cycle strobe; sound_out updated this cycle

Function
REQ-003 Envelope values 65..127 SHALL be clamped to 64 before use.
REQ-004 Stage 1 SHALL compute p1 = (wave_data * env_clamped) >>> 6, arithmetic shift with floor rounding; result is 8-bit signed in -128..127.
REQ-005 Stage 2 SHALL compute p2 = p1 * volume of the sampled channel, 12-bit signed in -1920..1905; p2 = 0 when the channel's reg_ch_enable bit is 0.
REQ-006 Each stage SHALL be registered, carrying the channel index and a slot-valid flag. Slot-valid is 0 for active 5..7.
REQ-007 Frame FSM states: WAIT (waiting for channel 0) and ACCUM (collecting channels in order). The FSM is evaluated on stage-2 output slots.
REQ-008 Behaviour by slot:
- Slot-invalid (active 5..7): ignored. It is a bubble, not a break, and holds FSM state and accumulator.
- Channel 0 in any state: acc <= p2, expected <= 1, go to ACCUM.
- In ACCUM, channel == expected (1..3): acc <= acc + p2, expected++.
- In ACCUM, channel 4 == expected: sound_out <= acc + p2 (15-bit signed, range -9600..9525); sound_valid = 1 for exactly one cycle; go to WAIT.
- Out-of-order channel index (not 0, not expected): discard the frame and go to WAIT. No sound_valid.
REQ-009 Latency: sound_valid SHALL assert in the cycle after the third rising edge following the edge that sampled active=4 (3-clock latency).
REQ-010 sound_out SHALL hold its last value between strobes.
REQ-011 sound_valid SHALL never assert for a frame missing any of channels 0..4.
REQ-012 Register inputs (volumes, enables) SHALL be sampled at stage 1 together with the slot data.

Reset
REQ-013 While reset=1 at a rising edge, the following SHALL clear to 0: sound_out, sound_valid, accumulator, all pipeline valid flags, expected. FSM goes to WAIT.
REQ-014 Reset asserted mid-frame SHALL discard the partial frame. The first strobe after reset requires a complete channel 0..4 sequence sampled after reset release.

Configuration
REQ-015 Macro WTS_MIXER_CLIP_EN:
- Defined: the final sum SHALL saturate to -2048..2047 before sound_out is loaded, sign-extended to 15 bits.
- Undefined: the full 15-bit sum SHALL be output unmodified.

Structure
REQ-016 Package wts_mixer_pkg SHALL hold:
- constants CH_NUM=5, SLOT_NOP=5, ENV_MAX=64, WAVE_W=8, ENV_W=7, VOL_W=4, OUT_W=15
- typedef for the pipeline slot record (channel index, valid, data)
- frame FSM enum {WAIT, ACCUM}
REQ-017 Stages 1–2 (clamp, multiply, shift, volume, enable mask) SHALL be sub-module wts_channel_scaler. Accumulator and FSM SHALL reside in wts_channel_mixer.

Verification
REQ-018 Bench SHALL cover:
- Reset held 20 cycles with random inputs -> sound_out=0, sound_valid=0 throughout.
- Channels 0..4 with wave=127, env=64, vol=15, all enabled -> one strobe with sound_out=9525 (2047 with WTS_MIXER_CLIP_EN); strobe lands 3 cycles after the ch4 sample.
- Ch0 wave=-128, env=100 (clamps to 64), vol=15; ch1..4 env=0 -> sound_out=-1920.
- All channels wave=-1, env=1, vol=1 -> sound_out=-5 (floor rounding). Same frame with reg_ch_enable=5'b00001 -> -1.
- Sequence 0,1,5,5,2,3,4 -> valid strobe (bubbles tolerated). Sequence 0,1,3,4 -> no strobe; a following 0..4 frame strobes normally.
- Reset pulsed after ch2 of a frame, then ch3,4 supplied -> no strobe. Next full frame strobes correct value.

Source files
------------

// File: rtl/wts_mixer_pkg.sv
// Shared constants, pipeline slot record and frame FSM encoding for the
// wave-table channel mixer.
package wts_mixer_pkg;

  localparam int CH_NUM   = 5;
  localparam int SLOT_NOP = 5;
  localparam int ENV_MAX  = 64;
  localparam int WAVE_W   = 8;
  localparam int ENV_W    = 7;
  localparam int VOL_W    = 4;
  localparam int OUT_W    = 15;
  localparam int CH_W     = 3;
  localparam int P1_W     = 8;
  localparam int P2_W     = 12;

  typedef struct packed {
    logic [CH_W-1:0]        ch;
    logic                   vld;
    logic signed [P2_W-1:0] data;
  } slot_t;

  typedef enum logic {
    WAIT  = 1'b0,
    ACCUM = 1'b1
  } frame_state_e;

endpackage

// File: rtl/wts_channel_scaler.sv
// Per-slot scaling pipeline: input capture, envelope clamp/scale, then
// channel volume and enable mask. Output is the stage-2 slot record.
module wts_channel_scaler
  import wts_mixer_pkg::*;
#(
  parameter int DATA_W = WAVE_W,
  parameter int COEF_W = ENV_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CH_W-1:0]           i_active,
  input  logic [COEF_W-1:0]         i_envelope,
  input  logic signed [DATA_W-1:0]  i_wave_data,
  input  logic [CH_NUM*VOL_W-1:0]   i_volumes,
  input  logic [CH_NUM-1:0]         i_ch_enable,
  output slot_t                     o_slot_p2
);

  function automatic logic [COEF_W-1:0] clamp_env(input logic [COEF_W-1:0] e);
    return (e > COEF_W'(ENV_MAX)) ? COEF_W'(ENV_MAX) : e;
  endfunction

  // Envelope is at most 64, so >>>6 of the product always fits 8 bits signed.
  function automatic logic signed [P1_W-1:0] env_scale(input logic signed [DATA_W-1:0] w,
                                                       input logic [COEF_W-1:0] e);
    logic signed [DATA_W+COEF_W:0] prod;
    prod = w * $signed({1'b0, e});
    return prod[P1_W+5:6];
  endfunction

  function automatic logic signed [P2_W-1:0] vol_scale(input logic signed [P1_W-1:0] p,
                                                       input logic [VOL_W-1:0] v,
                                                       input logic en);
    logic signed [P1_W+VOL_W:0] prod;
    prod = p * $signed({1'b0, v});
    return en ? prod[P2_W-1:0] : '0;
  endfunction

  logic [VOL_W-1:0] w_vol;
  logic             w_en;
  logic             w_vld;

  always_comb begin
    w_vol = '0;
    w_en  = 1'b0;
    w_vld = 1'b0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (i_active == CH_W'(c)) begin
        w_vld = 1'b1;
        w_vol = i_volumes[c*VOL_W +: VOL_W];
        w_en  = i_ch_enable[c];
      end
    end
  end

  logic                     r_vld_p0, r_vld_p1, r_vld_p2;
  logic [CH_W-1:0]          r_ch_p0, r_ch_p1, r_ch_p2;
  logic [COEF_W-1:0]        r_env_p0;
  logic signed [DATA_W-1:0] r_wave_p0;
  logic [VOL_W-1:0]         r_vol_p0, r_vol_p1;
  logic                     r_en_p0, r_en_p1;
  logic signed [P1_W-1:0]   r_data_p1;
  logic signed [P2_W-1:0]   r_data_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p0 <= w_vld;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    // p0: capture slot with its channel's volume and enable
    r_ch_p0   <= i_active;
    r_env_p0  <= i_envelope;
    r_wave_p0 <= i_wave_data;
    r_vol_p0  <= w_vol;
    r_en_p0   <= w_en;
    // p1: envelope clamp and scale
    r_ch_p1   <= r_ch_p0;
    r_data_p1 <= env_scale(r_wave_p0, clamp_env(r_env_p0));
    r_vol_p1  <= r_vol_p0;
    r_en_p1   <= r_en_p0;
    // p2: volume and enable mask
    r_ch_p2   <= r_ch_p1;
    r_data_p2 <= vol_scale(r_data_p1, r_vol_p1, r_en_p1);
  end

  always_comb begin
    o_slot_p2      = '0;
    o_slot_p2.ch   = r_ch_p2;
    o_slot_p2.vld  = r_vld_p2;
    o_slot_p2.data = r_data_p2;
  end

endmodule

// File: rtl/wts_channel_mixer.sv
// Five-channel mixer: scaler pipeline feeding a frame accumulator FSM.
// Optional WTS_MIXER_CLIP_EN saturates the frame sum to -2048..2047.
module wts_channel_mixer
  import wts_mixer_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CH_W-1:0]          active,
  input  logic [ENV_W-1:0]         envelope,
  input  logic signed [WAVE_W-1:0] wave_data,
  input  logic [VOL_W-1:0]         reg_volume_a,
  input  logic [VOL_W-1:0]         reg_volume_b,
  input  logic [VOL_W-1:0]         reg_volume_c,
  input  logic [VOL_W-1:0]         reg_volume_d,
  input  logic [VOL_W-1:0]         reg_volume_e,
  input  logic [CH_NUM-1:0]        reg_ch_enable,
  output logic signed [OUT_W-1:0]  sound_out,
  output logic                     sound_valid
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH_NUM - 1);

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [OUT_W-1:0] s);
`ifdef WTS_MIXER_CLIP_EN
    if (s > 15'sd2047)       return 15'sd2047;
    else if (s < -15'sd2048) return -15'sd2048;
    else                     return s;
`else
    return s;
`endif
  endfunction

  slot_t w_slot;

  wts_channel_scaler u_scaler (
    .clk         (clk),
    .reset       (reset),
    .i_active    (active),
    .i_envelope  (envelope),
    .i_wave_data (wave_data),
    .i_volumes   ({reg_volume_e, reg_volume_d, reg_volume_c, reg_volume_b, reg_volume_a}),
    .i_ch_enable (reg_ch_enable),
    .o_slot_p2   (w_slot)
  );

  frame_state_e             r_state, w_state_nxt;
  logic [CH_W-1:0]          r_expected, w_exp_nxt;
  logic signed [OUT_W-1:0]  r_acc, w_acc_nxt, w_sum, w_p2_ext;
  logic signed [OUT_W-1:0]  r_sound_out;
  logic                     r_sound_valid, w_strobe;

  assign w_p2_ext = {{(OUT_W-P2_W){w_slot.data[P2_W-1]}}, w_slot.data};
  assign w_sum    = r_acc + w_p2_ext;

  // Invalid slots are bubbles: every default holds state.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_expected;
    w_acc_nxt   = r_acc;
    w_strobe    = 1'b0;
    if (w_slot.vld) begin
      if (w_slot.ch == '0) begin
        w_acc_nxt   = w_p2_ext;
        w_exp_nxt   = CH_W'(1);
        w_state_nxt = ACCUM;
      end else if (r_state == ACCUM && w_slot.ch == r_expected) begin
        if (r_expected == LAST_CH) begin
          w_strobe    = 1'b1;
          w_exp_nxt   = '0;
          w_state_nxt = WAIT;
        end else begin
          w_acc_nxt = w_sum;
          w_exp_nxt = r_expected + CH_W'(1);
        end
      end else begin
        w_exp_nxt   = '0;
        w_state_nxt = WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= WAIT;
      r_expected    <= '0;
      r_acc         <= '0;
      r_sound_out   <= '0;
      r_sound_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_expected    <= w_exp_nxt;
      r_acc         <= w_acc_nxt;
      r_sound_valid <= w_strobe;
      if (w_strobe) r_sound_out <= sat_out(w_sum);
    end
  end

  assign sound_out   = r_sound_out;
  assign sound_valid = r_sound_valid;

endmodule

// File: tb/tb_wts_channel_mixer.sv
// Directed and randomized bench for wts_channel_mixer against a frame-level
// arithmetic model.
module tb_wts_channel_mixer;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [2:0]         active = 3'd5;
  logic [6:0]         envelope = '0;
  logic signed [7:0]  wave_data = '0;
  logic [3:0]         reg_volume_a = '0, reg_volume_b = '0, reg_volume_c = '0;
  logic [3:0]         reg_volume_d = '0, reg_volume_e = '0;
  logic [4:0]         reg_ch_enable = '0;
  logic signed [14:0] sound_out;
  logic               sound_valid;

  wts_channel_mixer dut (
    .clk           (clk),
    .reset         (reset),
    .active        (active),
    .envelope      (envelope),
    .wave_data     (wave_data),
    .reg_volume_a  (reg_volume_a),
    .reg_volume_b  (reg_volume_b),
    .reg_volume_c  (reg_volume_c),
    .reg_volume_d  (reg_volume_d),
    .reg_volume_e  (reg_volume_e),
    .reg_ch_enable (reg_ch_enable),
    .sound_out     (sound_out),
    .sound_valid   (sound_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobes = 0;
  int last_val = 0;
  int strobe_cyc = 0;
  int ch4_cyc = 0;

  int wv [5];
  int ev [5];
  int vol [5];
  int en;

`ifdef WTS_MIXER_CLIP_EN
  localparam int EXP_MAX = 2047;
`else
  localparam int EXP_MAX = 9525;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sound_valid === 1'b1) begin
      strobes    = strobes + 1;
      last_val   = int'(sound_out);
      strobe_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_p2(input int w, input int e, input int v, input bit on);
    int ec, p, q;
    ec = (e > 64) ? 64 : e;
    p  = w * ec;
    q  = p / 64;
    if (p < 0 && (p % 64) != 0) q = q - 1;
    return on ? q * v : 0;
  endfunction

  function automatic int model_frame();
    int s = 0;
    for (int c = 0; c < 5; c++) s += ref_p2(wv[c], ev[c], vol[c], en[c]);
`ifdef WTS_MIXER_CLIP_EN
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
`endif
    return s;
  endfunction

  task automatic apply_regs();
    reg_volume_a  = 4'(vol[0]);
    reg_volume_b  = 4'(vol[1]);
    reg_volume_c  = 4'(vol[2]);
    reg_volume_d  = 4'(vol[3]);
    reg_volume_e  = 4'(vol[4]);
    reg_ch_enable = 5'(en);
  endtask

  task automatic drive(input int act, input int e, input int w);
    active    = 3'(act);
    envelope  = 7'(e);
    wave_data = 8'(w);
    @(posedge clk);
    #1;
    if (act == 4) ch4_cyc = cyc;
  endtask

  task automatic send_ch(input int c);
    drive(c, ev[c], wv[c]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(5, $urandom_range(0, 127), $urandom_range(0, 255));
  endtask

  task automatic full_frame();
    for (int c = 0; c < 5; c++) send_ch(c);
  endtask

  task automatic frame_check(input string tag, input int exp);
    int s0;
    s0 = strobes;
    full_frame();
    idle(6);
    chk({tag, "_cnt"}, strobes - s0, 1);
    chk({tag, "_val"}, last_val, exp);
    chk({tag, "_hold"}, int'(sound_out), exp);
  endtask

  task automatic set_all(input int w, input int e, input int v, input int enable);
    for (int c = 0; c < 5; c++) begin
      wv[c] = w; ev[c] = e; vol[c] = v;
    end
    en = enable;
    apply_regs();
  endtask

  initial begin
    int s0;
    int exp_v;

    // Reset held with random inputs
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      active        = 3'($urandom_range(0, 7));
      envelope      = 7'($urandom_range(0, 127));
      wave_data     = 8'($urandom_range(0, 255));
      reg_volume_a  = 4'($urandom_range(0, 15));
      reg_volume_c  = 4'($urandom_range(0, 15));
      reg_ch_enable = 5'($urandom_range(0, 31));
      @(posedge clk);
      #1;
      chk("rst_out", int'(sound_out), 0);
      chk("rst_vld", int'(sound_valid), 0);
    end
    reset  = 1'b0;
    active = 3'd5;
    idle(3);
    chk("post_rst_strobes", strobes, 0);

    // Maximum positive frame with latency check
    set_all(127, 64, 15, 5'h1F);
    frame_check("max", EXP_MAX);
    chk("max_model", last_val, model_frame());
    chk("latency", strobe_cyc - ch4_cyc, 3);

    // Clamped envelope on ch0, other channels silent
    set_all(0, 0, 15, 5'h1F);
    wv[0] = -128; ev[0] = 100;
    for (int c = 1; c < 5; c++) wv[c] = $urandom_range(0, 255) - 128;
    frame_check("clamp", -1920);

    // Floor rounding, then enable mask
    set_all(-1, 1, 1, 5'h1F);
    frame_check("floor", -5);
    set_all(-1, 1, 1, 5'h01);
    frame_check("floor_en", -1);

    // Bubbles inside a frame
    set_all(50, 40, 7, 5'h1F);
    wv[2] = -90; ev[3] = 90;
    exp_v = model_frame();
    s0 = strobes;
    send_ch(0); send_ch(1); drive(5, 0, 0); drive(6, 0, 0); send_ch(2); send_ch(3); send_ch(4);
    idle(6);
    chk("bubble_cnt", strobes - s0, 1);
    chk("bubble_val", last_val, exp_v);

    // Out-of-order frame is dropped, following frame still strobes
    set_all(33, 64, 9, 5'h1F);
    s0 = strobes;
    send_ch(0); send_ch(1); send_ch(3); send_ch(4);
    idle(6);
    chk("ooo_cnt", strobes - s0, 0);
    chk("ooo_hold", int'(sound_out), exp_v);
    frame_check("ooo_next", model_frame());

    // Reset mid-frame discards the partial frame
    set_all(-77, 64, 11, 5'h1F);
    s0 = strobes;
    send_ch(0); send_ch(1); send_ch(2);
    reset = 1'b1;
    drive(5, 0, 0);
    reset = 1'b0;
    chk("midrst_out", int'(sound_out), 0);
    send_ch(3); send_ch(4);
    idle(6);
    chk("midrst_cnt", strobes - s0, 0);
    frame_check("midrst_next", model_frame());

    // Randomized frames with occasional bubbles
    for (int n = 0; n < 25; n++) begin
      for (int c = 0; c < 5; c++) begin
        wv[c]  = $urandom_range(0, 255) - 128;
        ev[c]  = $urandom_range(0, 127);
        vol[c] = $urandom_range(0, 15);
      end
      en = $urandom_range(0, 31);
      apply_regs();
      exp_v = model_frame();
      s0 = strobes;
      for (int c = 0; c < 5; c++) begin
        send_ch(c);
        if ($urandom_range(0, 3) == 0) drive($urandom_range(5, 7), 0, 0);
      end
      idle(5);
      chk("rnd_cnt", strobes - s0, 1);
      chk("rnd_val", last_val, exp_v);
      chk("rnd_hold", int'(sound_out), exp_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
